jingle_player: RTL and testbench



---
 rtl/sound_pkg.sv | 49 ++++
 rtl/jingle_player_if.sv | 33 +++
 rtl/note_rom.sv | 20 ++
 rtl/jingle_player.sv | 146 ++++++++++++++
 tb/tb_jingle_player.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared constants and types for the jingle sequencer.
// Holds the note table, melody/state enums and the melody lookup helper.
package sound_pkg;

    localparam int HP_W  = 17;
    localparam int DUR_W = 24;

    // Half-periods in clocks at 50 MHz
    localparam logic [HP_W-1:0] HP_C4 = 17'd95556;
    localparam logic [HP_W-1:0] HP_E4 = 17'd75843;
    localparam logic [HP_W-1:0] HP_F4 = 17'd71586;
    localparam logic [HP_W-1:0] HP_G4 = 17'd63776;
    localparam logic [HP_W-1:0] HP_C5 = 17'd47778;
    localparam logic [HP_W-1:0] HP_E5 = 17'd37922;
    localparam logic [HP_W-1:0] HP_G5 = 17'd31888;
    localparam logic [HP_W-1:0] HP_C6 = 17'd23889;

    typedef enum logic {
        MEL_WIN  = 1'b0,
        MEL_LOSE = 1'b1
    } melody_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [HP_W-1:0] melody_note(
        input melody_t    mel,
        input logic [1:0] idx
    );
        logic [HP_W-1:0] hp;
        hp = HP_C5;
        unique case ({mel == MEL_LOSE, idx})
            3'b000: hp = HP_C5;
            3'b001: hp = HP_E5;
            3'b010: hp = HP_G5;
            3'b011: hp = HP_C6;
            3'b100: hp = HP_G4;
            3'b101: hp = HP_F4;
            3'b110: hp = HP_E4;
            3'b111: hp = HP_C4;
            default: hp = HP_C5;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/jingle_player_if.sv
// Trigger/status bundle between the game logic and the jingle player.
// The player takes the slave side; the game logic the master side.
interface jingle_player_if;

    logic       win;
    logic       lose;
    logic       mute;
    logic       audio_out;
    logic       busy;
    logic [1:0] note_idx;
    logic       done;

    modport master (
        output win,
        output lose,
        output mute,
        input  audio_out,
        input  busy,
        input  note_idx,
        input  done
    );

    modport slave (
        input  win,
        input  lose,
        input  mute,
        output audio_out,
        output busy,
        output note_idx,
        output done
    );

endinterface

// File: rtl/note_rom.sv
// Combinational note lookup: melody and note index to a scaled half-period.
// A large shift can zero the value, so the result is clamped to one clock.
module note_rom
    import sound_pkg::*;
#(
    parameter int PITCH_SHIFT = 0
) (
    input  melody_t         mel_i,
    input  logic [1:0]      idx_i,
    output logic [HP_W-1:0] hp_o
);

    logic [HP_W-1:0] shifted;

    always_comb begin
        shifted = melody_note(mel_i, idx_i) >> PITCH_SHIFT;
        hp_o    = (shifted == '0) ? HP_W'(1) : shifted;
    end

endmodule

// File: rtl/jingle_player.sv
// Four-note win/lose jingle sequencer driving a 1-bit square-wave speaker.
// Sequencing FSM plus duration counter, half-period counter and wave register.
module jingle_player
    import sound_pkg::*;
#(
    parameter int NOTE_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int PITCH_SHIFT = 0
) (
    input  logic            clk,
    input  logic            reset,
    jingle_player_if.slave  bus
);

    localparam logic [DUR_W-1:0] NOTE_LD = DUR_W'(NOTE_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LD  = DUR_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [1:0]       idx_q, idx_d;
    melody_t          mel_q, mel_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             wave_q, wave_d;
    logic             done_q, done_d;

    logic             trig;
    melody_t          trig_mel;
    logic             dur_zero;
    logic             note_start;
    logic [HP_W-1:0]  hp_cur;

    assign trig     = bus.win | bus.lose;
    assign trig_mel = bus.lose ? MEL_LOSE : MEL_WIN;
    assign dur_zero = (dur_q == '0);

    // Looked up on next-state values so a new note loads its own pitch
    note_rom #(
        .PITCH_SHIFT(PITCH_SHIFT)
    ) u_rom (
        .mel_i(mel_d),
        .idx_i(idx_d),
        .hp_o (hp_cur)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            idx_q   <= '0;
            mel_q   <= MEL_WIN;
            hp_q    <= '0;
            wave_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            mel_q   <= mel_d;
            hp_q    <= hp_d;
            wave_q  <= wave_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        idx_d      = idx_q;
        mel_d      = mel_q;
        done_d     = 1'b0;
        note_start = 1'b0;
        if (trig) begin
            state_d    = ST_TONE;
            dur_d      = NOTE_LD;
            idx_d      = '0;
            mel_d      = trig_mel;
            note_start = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    dur_d = '0;
                end
                ST_TONE: begin
                    if (dur_zero) begin
                        state_d = ST_GAP;
                        dur_d   = GAP_LD;
                    end else begin
                        dur_d = dur_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!dur_zero) begin
                        dur_d = dur_q - 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        dur_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_TONE;
                        dur_d      = NOTE_LD;
                        idx_d      = idx_q + 1'b1;
                        note_start = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dur_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Each note starts high with a fresh half-period count
    always_comb begin
        hp_d   = hp_q;
        wave_d = wave_q;
        priority case (1'b1)
            note_start: begin
                hp_d   = hp_cur - 1'b1;
                wave_d = 1'b1;
            end
            (state_d == ST_TONE): begin
                if (hp_q == '0) begin
                    hp_d   = hp_cur - 1'b1;
                    wave_d = ~wave_q;
                end else begin
                    hp_d = hp_q - 1'b1;
                end
            end
            default: begin
                hp_d   = '0;
                wave_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.audio_out = wave_q & ~bus.mute;
        bus.note_idx  = idx_q;
        bus.done      = done_q;
    end

endmodule

// File: tb/tb_jingle_player.sv
// Self-checking bench: two jingle players checked every cycle against a
// time-based melody model (note = elapsed / period, phase = offset / HP).
module tb_jingle_player;

    localparam int NA = 20;
    localparam int GA = 4;
    localparam int SA = 12;
    localparam int NB = 64000;
    localparam int GB = 16;
    localparam int SB = 0;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    jingle_player_if bus_a ();
    jingle_player_if bus_b ();

    jingle_player #(
        .NOTE_CYCLES(NA),
        .GAP_CYCLES (GA),
        .PITCH_SHIFT(SA)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    jingle_player #(
        .NOTE_CYCLES(NB),
        .GAP_CYCLES (GB),
        .PITCH_SHIFT(SB)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    int ncmp = 0;
    int nfail = 0;

    // Row 0 = win melody, row 1 = lose melody, raw half-periods
    int tbl [2][4] = '{'{47778, 37922, 31888, 23889},
                       '{63776, 71586, 75843, 95556}};

    bit act  [2];
    int mel  [2];
    int k    [2];
    bit dexp [2];
    int nc   [2] = '{NA, NB};
    int gc   [2] = '{GA, GB};
    int sh   [2] = '{SA, SB};

    function automatic int eff_hp(int m, int n, int s);
        int v;
        v = tbl[m][n] >> s;
        return (v < 1) ? 1 : v;
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic upd(int d, logic rst, logic w, logic l);
        dexp[d] = 1'b0;
        if (rst) begin
            act[d] = 1'b0;
        end else if (w || l) begin
            act[d] = 1'b1;
            k[d]   = 0;
            mel[d] = l ? 1 : 0;
        end else if (act[d]) begin
            k[d]++;
            if (k[d] == 4 * (nc[d] + gc[d])) begin
                act[d]  = 1'b0;
                dexp[d] = 1'b1;
            end
        end
    endtask

    task automatic chk(int d, logic b, logic a, logic [1:0] ni,
                       logic dn, logic mu);
        int    per;
        int    note;
        int    off;
        bit    wave;
        string p;
        p    = d ? "B" : "A";
        per  = nc[d] + gc[d];
        note = act[d] ? k[d] / per : 0;
        off  = k[d] % per;
        wave = act[d] && (off < nc[d]) &&
               (((off / eff_hp(mel[d], note, sh[d])) % 2) == 0);
        cmp({p, " busy"}, 32'(b), 32'(act[d]));
        cmp({p, " note_idx"}, 32'(ni), 32'(note));
        cmp({p, " done"}, 32'(dn), 32'(dexp[d]));
        cmp({p, " audio_out"}, 32'(a), 32'(wave & ~mu));
    endtask

    task automatic step();
        @(posedge clk);
        upd(0, reset, bus_a.win, bus_a.lose);
        upd(1, reset, bus_b.win, bus_b.lose);
        @(negedge clk);
        chk(0, bus_a.busy, bus_a.audio_out, bus_a.note_idx,
            bus_a.done, bus_a.mute);
        chk(1, bus_b.busy, bus_b.audio_out, bus_b.note_idx,
            bus_b.done, bus_b.mute);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic pulse_a(logic w, logic l);
        bus_a.win  = w;
        bus_a.lose = l;
        step();
        bus_a.win  = 1'b0;
        bus_a.lose = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus_a.win  = 1'b0;
        bus_a.lose = 1'b0;
        bus_a.mute = 1'b0;
        bus_b.win  = 1'b0;
        bus_b.lose = 1'b0;
        bus_b.mute = 1'b0;
        for (int d = 0; d < 2; d++) begin
            act[d]  = 1'b0;
            mel[d]  = 0;
            k[d]    = 0;
            dexp[d] = 1'b0;
        end

        // Reset state
        run(3);
        reset = 1'b0;
        run(3);

        // Win melody, natural completion
        pulse_a(1'b1, 1'b0);
        run(100);

        // Simultaneous win and lose: lose wins
        pulse_a(1'b1, 1'b1);
        run(100);

        // Lose, restarted by win during note 2
        pulse_a(1'b0, 1'b1);
        run(54);
        pulse_a(1'b1, 1'b0);
        run(100);

        // Muted win melody
        bus_a.mute = 1'b1;
        pulse_a(1'b1, 1'b0);
        run(100);
        bus_a.mute = 1'b0;

        // Trigger on the final gap cycle restarts without done
        pulse_a(1'b1, 1'b0);
        run(94);
        pulse_a(1'b0, 1'b1);
        run(100);

        // Asynchronous reset mid-tone
        pulse_a(1'b1, 1'b0);
        run(5);
        #2 reset = 1'b1;
        #1;
        cmp("A async busy", 32'(bus_a.busy), 32'd0);
        cmp("A async audio_out", 32'(bus_a.audio_out), 32'd0);
        cmp("A async note_idx", 32'(bus_a.note_idx), 32'd0);
        cmp("A async done", 32'(bus_a.done), 32'd0);
        act[0] = 1'b0;
        step();
        reset = 1'b0;
        run(30);

        // Randomised triggers and mute
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            bus_a.win  = (r < 3) || (r == 10);
            bus_a.lose = (r >= 3 && r < 6) || (r == 10);
            if (r >= 20 && r < 24) bus_a.mute = ~bus_a.mute;
            step();
            bus_a.win  = 1'b0;
            bus_a.lose = 1'b0;
        end
        bus_a.mute = 1'b0;
        run(100);

        // Unshifted pitch: full G4 note then start of F4
        bus_b.lose = 1'b1;
        step();
        bus_b.lose = 1'b0;
        run(NB + GB + 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
